// File: rtl/regfile_pkg.sv
// Shared types and default datapath sizes for the register file,
// decoder and ALU.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;
    localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once writing zero, then
// raises ready and stays in RUN until the next reset.
module rf_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q, ready_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; next-state logic lives in always_comb.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= ready_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_we_o = 1'b0;
        unique case (state_q)
            RF_CLEAR: begin
                clr_we_o = 1'b1;
                ptr_d    = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
        ready_d = (state_d == RF_RUN);
    end

    assign ready_o    = ready_q;
    assign clr_addr_o = ptr_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: NUM_RD registered read ports with a shared
// valid strobe, optional write bypass and optional hardwired-zero R0.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int NUM_RD  = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic                     rd_valid_q;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;

    rf_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .ready_o    (ready),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    assign user_we   = ready && wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));
    assign arr_we    = rst_n && (clr_we || user_we);
    assign arr_waddr = clr_we ? clr_addr : wr_addr;
    assign arr_wdata = clr_we ? '0 : wr_data;

    // NOTE: the array has no reset branch; the clear sequencer zeroes it,
    // which keeps it mappable to plain storage.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_q[arr_waddr] <= arr_wdata;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
        logic [ADDR_W-1:0] raddr;
        logic              zero_hit;
        logic              byp_hit;

        assign raddr    = rd_addr[p*ADDR_W +: ADDR_W];
        assign zero_hit = (ZERO_R0 != 0) && (raddr == '0);
        assign byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == raddr);
        assign rd_data_d[p*DATA_W +: DATA_W] = zero_hit ? '0
                                             : byp_hit  ? wr_data
                                             :            mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ready && rd_en;
            if (ready && rd_en) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three builds (default, no bypass, zero R0) share
// one stimulus stream and are checked against a behavioural array model.
module tb_regfile_param;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;

    // Build 0: defaults; build 1: BYPASS=0; build 2: ZERO_R0=1.
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        rready [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_mem [3][8];
    logic [31:0] exp_rd [3];
    logic        exp_valid;
    logic        m_ready;
    int          m_clr;

    regfile_param dut_def (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdata[0]), .rd_valid(rvalid[0]), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .ready(rready[0])
    );

    regfile_param #(.BYPASS(0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdata[1]), .rd_valid(rvalid[1]), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .ready(rready[1])
    );

    regfile_param #(.ZERO_R0(1)) dut_zero (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rdata[2]), .rd_valid(rvalid[2]), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .ready(rready[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model of one rising edge, from the behavioural rules: reset clears the
    // outputs, the clear phase lasts 8 edges, then reads see pre-write data
    // unless bypass applies, and R0 reads zero in the zero-R0 build.
    task automatic model_edge();
        logic [2:0]  a;
        logic [15:0] w;
        if (!rst_n) begin
            m_ready   = 1'b0;
            m_clr     = 0;
            exp_valid = 1'b0;
            for (int v = 0; v < 3; v++) exp_rd[v] = '0;
        end else if (!m_ready) begin
            for (int v = 0; v < 3; v++) m_mem[v][m_clr] = '0;
            m_clr++;
            if (m_clr == 8) m_ready = 1'b1;
            exp_valid = 1'b0;
        end else begin
            exp_valid = rd_en;
            for (int v = 0; v < 3; v++) begin
                if (rd_en) begin
                    for (int p = 0; p < 2; p++) begin
                        a = rd_addr[p*3 +: 3];
                        if (v == 2 && a == 0)                     w = '0;
                        else if (wr_en && wr_addr == a && v != 1) w = wr_data;
                        else                                      w = m_mem[v][a];
                        exp_rd[v][p*16 +: 16] = w;
                    end
                end
                if (wr_en && !(v == 2 && wr_addr == 0)) m_mem[v][wr_addr] = wr_data;
            end
        end
    endtask

    task automatic tick(input logic rst, input logic rde, input logic [5:0] ra,
                        input logic wre, input logic [2:0] wa, input logic [15:0] wd);
        rst_n   = rst;
        rd_en   = rde;
        rd_addr = ra;
        wr_en   = wre;
        wr_addr = wa;
        wr_data = wd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 6'h3f, 1'b1, 3'd1, 16'hffff);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rready[v] !== 1'b0 || rvalid[v] !== 1'b0 || rdata[v] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs b%0d: got ready=%b valid=%b data=%h want 0/0/00000000",
                         v, rready[v], rvalid[v], rdata[v]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0, '0, '0);
            for (int v = 0; v < 3; v++) begin
                n_checks++;
                if (rready[v] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL clear_ready b%0d cycle %0d: got %b want %b", v, i + 1, rready[v], (i == 7));
                end
            end
        end
        for (int a = 0; a < 8; a++) begin
            tick(1'b1, 1'b1, {3'(a), 3'(a)}, 1'b0, '0, '0);
            for (int v = 0; v < 3; v++) begin
                n_checks++;
                if (rvalid[v] !== 1'b1 || rdata[v] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL clear_read b%0d r%0d: got valid=%b data=%h want 1/00000000",
                             v, a, rvalid[v], rdata[v]);
                end
            end
        end
        tick(1'b1, 1'b0, '0, 1'b0, '0, '0);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rvalid[v] !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_valid_drop b%0d: got %b want 0", v, rvalid[v]);
            end
        end
    endtask

    task automatic test_write_read();
        tick(1'b1, 1'b0, '0, 1'b1, 3'd3, 16'h1234);
        tick(1'b1, 1'b0, '0, 1'b1, 3'd5, 16'hbeef);
        tick(1'b1, 1'b1, {3'd5, 3'd3}, 1'b0, '0, '0);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rvalid[v] !== 1'b1 || rdata[v] !== 32'hbeef_1234) begin
                n_fail++;
                $display("FAIL wr_rd b%0d: got valid=%b data=%h want 1/beef1234", v, rvalid[v], rdata[v]);
            end
        end
        tick(1'b1, 1'b0, 6'h3f, 1'b0, '0, '0);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rvalid[v] !== 1'b0 || rdata[v] !== 32'hbeef_1234) begin
                n_fail++;
                $display("FAIL wr_rd_hold b%0d: got valid=%b data=%h want 0/beef1234", v, rvalid[v], rdata[v]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] want [3];
        want[0] = 32'haaaa_aaaa;
        want[1] = 32'h0000_0000;
        want[2] = 32'haaaa_aaaa;
        tick(1'b1, 1'b1, {3'd2, 3'd2}, 1'b1, 3'd2, 16'haaaa);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rdata[v] !== want[v]) begin
                n_fail++;
                $display("FAIL bypass_same_cycle b%0d: got %h want %h", v, rdata[v], want[v]);
            end
        end
        tick(1'b1, 1'b1, {3'd2, 3'd2}, 1'b0, '0, '0);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rdata[v] !== 32'haaaa_aaaa) begin
                n_fail++;
                $display("FAIL bypass_next_cycle b%0d: got %h want aaaaaaaa", v, rdata[v]);
            end
        end
    endtask

    task automatic test_zero_r0();
        logic [31:0] want [3];
        tick(1'b1, 1'b0, '0, 1'b1, 3'd0, 16'h5555);
        tick(1'b1, 1'b1, 6'd0, 1'b0, '0, '0);
        want[0] = 32'h5555_5555;
        want[1] = 32'h5555_5555;
        want[2] = 32'h0;
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rdata[v] !== want[v]) begin
                n_fail++;
                $display("FAIL zero_r0_read b%0d: got %h want %h", v, rdata[v], want[v]);
            end
        end
        tick(1'b1, 1'b1, 6'd0, 1'b1, 3'd0, 16'h6666);
        want[0] = 32'h6666_6666;
        want[1] = 32'h5555_5555;
        want[2] = 32'h0;
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rdata[v] !== want[v]) begin
                n_fail++;
                $display("FAIL zero_r0_bypass b%0d: got %h want %h", v, rdata[v], want[v]);
            end
        end
    endtask

    task automatic test_mid_clear_reset();
        tick(1'b1, 1'b0, '0, 1'b1, 3'd6, 16'h7777);
        tick(1'b1, 1'b1, {3'd6, 3'd6}, 1'b0, '0, '0);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rdata[v] !== 32'h7777_7777) begin
                n_fail++;
                $display("FAIL preload_r6 b%0d: got %h want 77777777", v, rdata[v]);
            end
        end
        tick(1'b0, 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, '0, 1'b0, '0, '0);
        tick(1'b0, 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0, '0, '0);
            for (int v = 0; v < 3; v++) begin
                n_checks++;
                if (rready[v] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL restart_ready b%0d cycle %0d: got %b want %b", v, i + 1, rready[v], (i == 7));
                end
            end
        end
        tick(1'b1, 1'b1, {3'd6, 3'd6}, 1'b0, '0, '0);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rvalid[v] !== 1'b1 || rdata[v] !== 32'h0) begin
                n_fail++;
                $display("FAIL restart_r6 b%0d: got valid=%b data=%h want 1/00000000", v, rvalid[v], rdata[v]);
            end
        end
    endtask

    task automatic test_not_ready();
        tick(1'b0, 1'b0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, {3'd1, 3'd1}, 1'b1, 3'd1, 16'h9999);
            for (int v = 0; v < 3; v++) begin
                n_checks++;
                if (rvalid[v] !== 1'b0 || rready[v] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL not_ready_ignore b%0d cycle %0d: got valid=%b ready=%b want 0/%b",
                             v, i + 1, rvalid[v], rready[v], (i == 7));
                end
            end
        end
        tick(1'b1, 1'b1, {3'd1, 3'd1}, 1'b0, '0, '0);
        for (int v = 0; v < 3; v++) begin
            n_checks++;
            if (rvalid[v] !== 1'b1 || rdata[v] !== 32'h0) begin
                n_fail++;
                $display("FAIL not_ready_r1 b%0d: got valid=%b data=%h want 1/00000000", v, rvalid[v], rdata[v]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, 1'($urandom), 6'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
            for (int v = 0; v < 3; v++) begin
                n_checks++;
                if (rready[v] !== m_ready || rvalid[v] !== exp_valid || rdata[v] !== exp_rd[v]) begin
                    n_fail++;
                    $display("FAIL random b%0d cycle %0d: got ready=%b valid=%b data=%h want %b/%b/%h",
                             v, i, rready[v], rvalid[v], rdata[v], m_ready, exp_valid, exp_rd[v]);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        m_ready   = 1'b0;
        m_clr     = 0;
        exp_valid = 1'b0;
        for (int v = 0; v < 3; v++) exp_rd[v] = '0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_r0();
        test_mid_clear_reset();
        test_not_ready();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-read-port register file for the CPU datapath, replacing the fixed 8×16, two-port file. Width, depth and read-port count are parameters. Reads are registered with a valid strobe. Same-cycle write-to-read bypass and a hardwired-zero R0 are configurable. After reset, a clear sequencer zeroes the array one entry per cycle and holds `ready` low until it finishes.

## Interface
- `DATA_W`, 16, register width in bits
- `ADDR_W`, 3, address width; depth `DEPTH = 2**ADDR_W`
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_R0`, 0, when 1 entry 0 reads as zero and ignores writes
- `BYPASS`, 1, when 1 a same-cycle write to a read address forwards `wr_data`
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset: one clock; reset is synchronous and active-low
- `rd_en`  in  1  read request, applies to all ports
- `rd_addr`  in  NUM_RD*ADDR_W  packed read addresses, port p at bits [p*ADDR_W +: ADDR_W]
- `rd_data`  out  NUM_RD*DATA_W  packed registered read data, same packing
- `rd_valid`  out  1  one-cycle strobe, `rd_data` updated this cycle
- `wr_en`  in  1  write request
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `ready`  out  1  high once clear sequence is complete

## Operation
- Reset (`rst_n`=0 at an edge): `rd_data`=0, `rd_valid`=0, `ready`=0. Sequencer enters CLEAR with pointer=0. Array contents are not touched by reset itself.
- Sequencer states: CLEAR and RUN.
  - CLEAR: each cycle writes 0 to entry[pointer] and increments the pointer. At pointer=DEPTH-1, it writes that entry, then goes to RUN and sets `ready`=1 on the same edge.
  - RUN: holds until the next reset.
- While `ready`=0, `rd_en` and `wr_en` are ignored. `rd_valid` stays 0 and no user write occurs.
- Reset asserted mid-CLEAR restarts the sequence from pointer 0. Reset asserted in RUN also returns to CLEAR.
- Write (RUN): at the edge where `wr_en`=1, entry[wr_addr] ← wr_data. If ZERO_R0=1 and wr_addr=0, the write is dropped.
- Read (RUN): at the edge where `rd_en`=1, each port p loads `rd_data[p]` with entry[rd_addr[p]]. `rd_valid` is 1 for the following cycle only.
  - Without `rd_en`, `rd_data` holds its value and `rd_valid`=0.
  - Repeated addresses across ports are legal and return identical data.
- Simultaneous read and write of the same address in one cycle:
  - BYPASS=1: the port returns `wr_data`.
  - BYPASS=0: the port returns the pre-write value.
  - The array is updated in both cases.
- ZERO_R0=1: any port addressing 0 returns 0, including when bypass conditions are met.
- Address widths equal the depth, so there are no out-of-range addresses and no wrap cases beyond the sequencer pointer.

## Timing
- Read latency: 1 cycle. Address presented at edge N gives data and `rd_valid` visible after edge N, and they hold through edge N+1.
- Write latency: 1 cycle. A read issued on the edge after a write sees the new value regardless of BYPASS.
- Clear duration: exactly DEPTH cycles after the first edge with `rst_n`=1. `ready` rises after edge DEPTH (8 for defaults).
- Back-to-back reads and writes are accepted every cycle. There is no backpressure.

## Structure
- Package `regfile_pkg`:
  - Sequencer state enum `rf_state_t` {RF_CLEAR, RF_RUN}.
  - Default width/depth constants shared with the decoder and ALU.
- Sub-module `rf_clear_ctrl`: state register, pointer counter, `ready` flag, clear-write address and enable. It is instantiated once.
- Top level: array, write mux (clear vs user), per-port read/bypass/zero logic built in a generate loop over NUM_RD.

## Test plan
- Reset, then idle: `ready`=0 for 8 cycles and 1 at cycle 8. A read of all addresses returns 0x0000 with `rd_valid` pulsing once per request.
- Write 0x1234→r3, then 0xBEEF→r5. Read ports (3,5) → `rd_data`={0xBEEF,0x1234} with `rd_valid` 1 for one cycle, then 0 with data held.
- Same-cycle write 0xAAAA→r2 and read port0=r2:
  - BYPASS=1 → 0xAAAA.
  - BYPASS=0 → previous 0x0000.
  - Next-cycle read → 0xAAAA in both builds.
- ZERO_R0=1: write 0x5555→r0, read r0 on all ports → 0x0000. Also the same-cycle write/read variant → 0x0000.
- Reset pulsed at clear cycle 4, with r6 preloaded 0x7777 before that reset:
  - `ready` stays 0 for 8 further cycles.
  - After `ready` rises, a read of r6 returns 0x0000.
- Requests while `ready`=0: a write of 0x9999→r1 and reads are ignored, with `rd_valid` staying 0. After `ready`, r1 reads 0x0000.
